// File: rtl/div_burst_ctrl.sv
// Sequencing controller for a 4-bit synchronous counter stage: loads a preset,
// reloads on terminal count to divide clk by N, and counts output pulses per burst.
module div_burst_ctrl #(
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         ratio,
  input  logic [BURST_W-1:0] bursts,
  input  logic               cnt_rco,
  output logic               cnt_load_n,
  output logic               cnt_ent,
  output logic [3:0]         cnt_d,
  output logic               pulse_out,
  output logic [BURST_W-1:0] pulse_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [3:0]         ratio_q;
  logic [BURST_W-1:0] bursts_q;
  logic [BURST_W-1:0] pulse_cnt_q;
  logic [BURST_W-1:0] pulse_cnt_d;
  logic               load_q;
  logic               ent_q;
  logic               pulse_q;
  logic               busy_q;
  logic               done_q;
  logic               burst_end;

  assign pulse_cnt_d = pulse_cnt_q + BURST_W'(1);
  assign burst_end   = (bursts_q != '0) && (pulse_cnt_d == bursts_q);

  // Preset is (16 - N) mod 16; a latched ratio of 0 (N = 16) naturally yields 0.
  assign cnt_d = 4'd0 - ratio_q;

  // In RUN the reload must land in the Q == 15 cycle itself, so it cannot wait a clock.
  assign cnt_load_n = ~(load_q | (ent_q & cnt_rco));
  assign cnt_ent    = ent_q;
  assign pulse_out  = pulse_q;
  assign pulse_cnt  = pulse_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // NOTE: all state is updated with non-blocking assignments in one clocked block,
  // so every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ratio_q     <= '0;
      bursts_q    <= '0;
      pulse_cnt_q <= '0;
      load_q      <= 1'b0;
      ent_q       <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            ratio_q     <= ratio;
            bursts_q    <= bursts;
            pulse_cnt_q <= '0;
            load_q      <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          load_q <= 1'b0;
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ent_q   <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            // Abort wins over a coincident terminal count: no pulse, no increment.
            ent_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_rco) begin
            pulse_q     <= 1'b1;
            pulse_cnt_q <= pulse_cnt_d;
            if (burst_end) begin
              ent_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          load_q  <= 1'b0;
          ent_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_burst_ctrl.sv
// Scoreboard bench for div_burst_ctrl: a behavioural 4-bit counter closes the loop,
// the driver queues expected pulse/done events, and a monitor pops and compares them.
`timescale 1ns/1ps
module tb_div_burst_ctrl;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          RST;
  logic          start;
  logic          stop;
  logic [3:0]    ratio;
  logic [BW-1:0] bursts;
  logic          cnt_rco;
  logic          cnt_load_n;
  logic          cnt_ent;
  logic [3:0]    cnt_d;
  logic          pulse_out;
  logic [BW-1:0] pulse_cnt;
  logic          busy;
  logic          done;

  typedef struct {
    bit          is_done;
    int unsigned cyc;
    int unsigned cnt;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned c0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  q_cnt;

  div_burst_ctrl #(.BURST_W(BW)) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .stop       (stop),
    .ratio      (ratio),
    .bursts     (bursts),
    .cnt_rco    (cnt_rco),
    .cnt_load_n (cnt_load_n),
    .cnt_ent    (cnt_ent),
    .cnt_d      (cnt_d),
    .pulse_out  (pulse_out),
    .pulse_cnt  (pulse_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous counter with load priority, as wired to the controller.
  always @(posedge clk or posedge RST) begin
    if (RST)              q_cnt <= 4'd0;
    else if (!cnt_load_n) q_cnt <= cnt_d;
    else if (cnt_ent)     q_cnt <= q_cnt + 4'd1;
  end
  assign cnt_rco = (q_cnt == 4'd15);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit is_done, input int unsigned at, input int unsigned cnt);
    ev_t e;
    e.is_done = is_done;
    e.cyc     = at;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  task automatic pop_and_check(input bit is_done);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got event at cycle %0d expected none",
               is_done ? "done" : "pulse", cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(is_done), 32'(e.is_done));
      check("ev_cycle", cyc, e.cyc);
      check("ev_pulse_cnt", 32'(pulse_cnt), e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (pulse_out) pop_and_check(1'b0);
    if (done)      pop_and_check(1'b1);
  end

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the start-sampling edge E0.
  task automatic do_start(input logic [3:0] r, input logic [BW-1:0] b, input logic [3:0] exp_d);
    ratio  = r;
    bursts = b;
    start  = 1'b1;
    @(negedge clk);
    c0    = cyc;
    start = 1'b0;
    check("load_cnt_d", 32'(cnt_d), 32'(exp_d));
    check("load_busy", 32'(busy), 32'd1);
    check("load_load_n", 32'(cnt_load_n), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_n"}, 32'(cnt_load_n), 32'd1);
    check({tag, "_ent"}, 32'(cnt_ent), 32'd0);
    check({tag, "_cnt_d"}, 32'(cnt_d), 32'd0);
    check({tag, "_pulse"}, 32'(pulse_out), 32'd0);
    check({tag, "_pulse_cnt"}, 32'(pulse_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    ratio  = 4'd0;
    bursts = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    RST = 1'b0;
    @(negedge clk);

    // N = 5, burst of 3: pulses at E6, E11, E16, done alongside the last one.
    push_ev(1'b0, 0, 0);
    exp_q.delete();
    do_start(4'd5, 8'd3, 4'd11);
    push_ev(1'b0, c0 + 6, 1);
    push_ev(1'b0, c0 + 11, 2);
    push_ev(1'b0, c0 + 16, 3);
    push_ev(1'b1, c0 + 16, 3);
    drain(40);
    @(negedge clk);
    check("b3_busy", 32'(busy), 32'd0);
    check("b3_pulse_cnt", 32'(pulse_cnt), 32'd3);
    check("b3_ent", 32'(cnt_ent), 32'd0);
    check("b3_load_n", 32'(cnt_load_n), 32'd1);
    repeat (8) @(negedge clk);

    // N = 1, burst of 4: four back-to-back pulses from E2.
    do_start(4'd1, 8'd4, 4'd15);
    for (int k = 0; k < 4; k++) push_ev(1'b0, c0 + 2 + k, k + 1);
    push_ev(1'b1, c0 + 5, 4);
    drain(20);
    repeat (4) @(negedge clk);
    check("n1_busy", 32'(busy), 32'd0);
    check("n1_pulse_cnt", 32'(pulse_cnt), 32'd4);

    // N = 3, continuous; stop coincides with the third terminal count.
    do_start(4'd3, 8'd0, 4'd13);
    push_ev(1'b0, c0 + 4, 1);
    push_ev(1'b0, c0 + 7, 2);
    repeat (9) @(negedge clk);
    check("stop_at_tc_load_n", 32'(cnt_load_n), 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_pulse", 32'(pulse_out), 32'd0);
    check("stop_pulse_cnt", 32'(pulse_cnt), 32'd2);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_ent", 32'(cnt_ent), 32'd0);
    drain(4);
    repeat (6) @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    ratio = 4'd7;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_load_n", 32'(cnt_load_n), 32'd1);
    check("start_stop_pulse_cnt", 32'(pulse_cnt), 32'd2);
    check("start_stop_cnt_d", 32'(cnt_d), 32'd13);
    repeat (3) @(negedge clk);

    // N = 4, burst of 3, with ratio change and a stray start mid-run.
    do_start(4'd4, 8'd3, 4'd12);
    push_ev(1'b0, c0 + 5, 1);
    push_ev(1'b0, c0 + 9, 2);
    push_ev(1'b0, c0 + 13, 3);
    push_ev(1'b1, c0 + 13, 3);
    @(negedge clk);
    @(negedge clk);
    ratio = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrun_cnt_d", 32'(cnt_d), 32'd12);
    drain(30);
    repeat (6) @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd0);

    // Reset in the middle of a continuous N = 5 run.
    do_start(4'd5, 8'd0, 4'd11);
    push_ev(1'b0, c0 + 6, 1);
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    RST = 1'b0;
    drain(2);
    repeat (3) @(negedge clk);

    // N = 16, continuous: 257 pulses so pulse_cnt wraps 255 -> 0 -> 1.
    do_start(4'd0, 8'd0, 4'd0);
    for (int k = 1; k <= 257; k++) push_ev(1'b0, c0 + 1 + 16 * k, k % 256);
    drain(16 * 260);
    @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("cont_pulse_cnt", 32'(pulse_cnt), 32'd1);
    check("cont_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
